// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder built from one full-adder cell and a
// carry flop. Operands arrive over a valid/ready handshake, are added LSB-first one
// bit per clock, and the sum plus carry-out are returned over a second handshake.
//
// Optional feature macro: SERIAL_ADDER_SUB_EN
//   defined   -> adds the in_sub port; in_sub=1 at accept computes A-B
//                (B stored inverted, initial carry forced to 1, out_cout=1 means A>=B).
//   undefined -> add only, no in_sub port.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for an operand pair; in_ready=1
// SHIFT | one full-adder step per edge, WIDTH edges in total; busy=1
// DONE  | result held on out_sum/out_cout with out_valid=1 until out_ready

module serial_adder_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // The last shift happens on the edge where the counter shows WIDTH-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH-1:0]   res;
    logic               carry;
    logic [CNT_W-1:0]   cnt;

    logic               fa_s;
    logic               fa_c;
    logic [WIDTH-1:0]   res_next;
    logic [WIDTH-1:0]   b_load;
    logic               c_load;

    // Single full-adder cell on the operand LSBs; the new sum bit enters the result MSB.
    always_comb begin
        fa_s     = op_a[0] ^ op_b[0] ^ carry;
        fa_c     = (op_a[0] & op_b[0]) | (op_b[0] & carry) | (op_a[0] & carry);
        res_next = (res >> 1) | {fa_s, {(WIDTH-1){1'b0}}};
    end

    // Operand B and initial carry as captured at accept (inverted B and carry=1 for subtract).
    always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
        b_load = in_sub ? ~in_b : in_b;
        c_load = in_sub ? 1'b1 : in_cin;
`else
        b_load = in_b;
        c_load = in_cin;
`endif
    end

    // Sequencer: accept, WIDTH shift steps, hold result until the consumer takes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            res       <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a     <= in_a;
                        op_b     <= b_load;
                        carry    <= c_load;
                        cnt      <= '0;
                        state    <= SHIFT;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                SHIFT: begin
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    res   <= res_next;
                    carry <= fa_c;
                    cnt   <= cnt + CNT_ONE;
                    if (cnt == CNT_LAST) begin
                        // Result is published straight from the final step so out_sum
                        // never shows partial sums.
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        out_sum   <= res_next;
                        out_cout  <= fa_c;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: an 8-bit and a 13-bit instance checked every cycle
// against a transaction-level model (accept time + result computed by plain addition).
module tb_serial_adder_ctrl;

    localparam int NW = 2;
    localparam int NOPS = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset     [NW];
    logic        in_valid  [NW];
    logic        in_ready  [NW];
    logic [63:0] in_a      [NW];
    logic [63:0] in_b      [NW];
    logic        in_cin    [NW];
    logic        in_sub    [NW];
    logic        out_valid [NW];
    logic        out_ready [NW];
    logic        out_cout  [NW];
    logic        busy      [NW];
    logic [63:0] out_sum   [NW];
    logic [7:0]  sum8;
    logic [12:0] sum13;

    assign out_sum[0] = 64'(sum8);
    assign out_sum[1] = 64'(sum13);

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_a(in_a[0][7:0]), .in_b(in_b[0][7:0]), .in_cin(in_cin[0]),
`ifdef SERIAL_ADDER_SUB_EN
        .in_sub(in_sub[0]),
`endif
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_sum(sum8),
        .out_cout(out_cout[0]), .busy(busy[0])
    );

    serial_adder_ctrl #(.WIDTH(13)) dut13 (
        .clk(clk), .reset(reset[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_a(in_a[1][12:0]), .in_b(in_b[1][12:0]), .in_cin(in_cin[1]),
`ifdef SERIAL_ADDER_SUB_EN
        .in_sub(in_sub[1]),
`endif
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_sum(sum13),
        .out_cout(out_cout[1]), .busy(busy[1])
    );

    int passed = 0;
    int total  = 0;
    bit chk_en = 1'b0;

    function automatic int wof(input int k);
        return (k == 0) ? 8 : 13;
    endfunction

    function automatic logic [63:0] wmask(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    // {cout,sum} straight from arithmetic: A + B + cin, or A + ~B + 1 for subtract.
    function automatic logic [63:0] ref_result(input int w, input logic [63:0] a,
                                               input logic [63:0] b, input logic cin,
                                               input logic sub);
        logic [63:0] m  = wmask(w);
        logic [63:0] bb = sub ? (~b & m) : (b & m);
        logic [63:0] c  = sub ? 64'd1 : {63'd0, cin};
        return (a & m) + bb + c;
    endfunction

    task automatic check(input string nm, input int k, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, k, act, exp, $time);
    endtask

    // Transaction model: an op is in flight from its accept edge until the handshake
    // edge; the result appears WIDTH edges after accept and stays until replaced.
    longint      cyc = 0;
    bit          m_busy [NW] = '{1'b0, 1'b0};
    longint      m_acc  [NW] = '{0, 0};
    logic [63:0] m_res  [NW];
    logic [63:0] m_sum  [NW] = '{64'd0, 64'd0};
    logic        m_cout [NW] = '{1'b0, 1'b0};
    int          ops_done [NW] = '{0, 0};

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < NW; k++) begin
            if (reset[k] === 1'b1) begin
                m_busy[k] <= 1'b0;
                m_sum[k]  <= 64'd0;
                m_cout[k] <= 1'b0;
            end else if (!m_busy[k]) begin
                if (in_valid[k] === 1'b1) begin
                    m_busy[k] <= 1'b1;
                    m_acc[k]  <= cyc + 1;
                    m_res[k]  <= ref_result(wof(k), in_a[k], in_b[k], in_cin[k], in_sub[k]);
                end
            end else begin
                if (cyc + 1 == m_acc[k] + longint'(wof(k))) begin
                    m_sum[k]  <= m_res[k] & wmask(wof(k));
                    m_cout[k] <= m_res[k][wof(k)];
                end
                if (cyc + 1 > m_acc[k] + longint'(wof(k)) && out_ready[k] === 1'b1) begin
                    m_busy[k]   <= 1'b0;
                    ops_done[k] <= ops_done[k] + 1;
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < NW; k++) begin
                bit ev;
                ev = m_busy[k] && (cyc >= m_acc[k] + longint'(wof(k)));
                check("in_ready",  k, in_ready[k],  !m_busy[k]);
                check("out_valid", k, out_valid[k], ev);
                check("busy",      k, busy[k],      m_busy[k] && !ev);
                check("out_sum",   k, out_sum[k],   m_sum[k]);
                check("out_cout",  k, out_cout[k],  m_cout[k]);
            end
        end
    end

    task automatic wait_idle(input int k);
        int n = 0;
        while (in_ready[k] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle", k, in_ready[k], 1'b1);
    endtask

    // Directed op on the 8-bit instance with literal expectations; optional
    // back-pressure hold and stray in_valid pulses while the op is in flight.
    task automatic dir_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input logic sub, input logic [8:0] lit, input int hold,
                          input bit pulse);
        int edges;
        wait_idle(0);
        in_a[0] = 64'(a); in_b[0] = 64'(b); in_cin[0] = cin; in_sub[0] = sub;
        in_valid[0] = 1'b1;
        check("model_pin", 0, ref_result(8, 64'(a), 64'(b), cin, sub), 64'(lit));
        @(negedge clk);
        in_valid[0] = 1'b0;
        in_a[0] = 64'($urandom); in_b[0] = 64'($urandom); in_cin[0] = $urandom_range(0, 1);
        edges = 1;
        while (out_valid[0] !== 1'b1 && edges < 40) begin
            in_valid[0] = (pulse && edges == 3);
            @(negedge clk);
            edges++;
        end
        in_valid[0] = 1'b0;
        // Edges counted including the accept edge.
        check("latency",  0, edges, 9);
        check("sum_lit",  0, out_sum[0], 64'(lit[7:0]));
        check("cout_lit", 0, out_cout[0], lit[8]);
        for (int i = 0; i < hold; i++) begin
            in_valid[0] = pulse;
            @(negedge clk);
            check("hold_sum",   0, out_sum[0], 64'(lit[7:0]));
            check("hold_cout",  0, out_cout[0], lit[8]);
            check("hold_valid", 0, out_valid[0], 1'b1);
            check("hold_ready", 0, in_ready[0], 1'b0);
        end
        // in_valid stays high on the release edge when pulsing: it must not be taken.
        in_valid[0]  = pulse;
        out_ready[0] = 1'b1;
        @(negedge clk);
        out_ready[0] = 1'b0;
        in_valid[0]  = 1'b0;
        check("release_valid", 0, out_valid[0], 1'b0);
        check("release_ready", 0, in_ready[0], 1'b1);
    endtask

    task automatic rand_drive(input int k);
        int guard = 0;
        int start = ops_done[k];
        while (ops_done[k] - start < NOPS && guard < 60000) begin
            @(negedge clk);
            in_valid[k]  = ($urandom_range(0, 3) != 0);
            in_a[k]      = {32'($urandom), 32'($urandom)} & wmask(wof(k));
            in_b[k]      = {32'($urandom), 32'($urandom)} & wmask(wof(k));
            in_cin[k]    = $urandom_range(0, 1);
`ifdef SERIAL_ADDER_SUB_EN
            in_sub[k]    = $urandom_range(0, 1);
`endif
            out_ready[k] = $urandom_range(0, 1);
            guard++;
        end
        in_valid[k] = 1'b0;
        check("ops_completed", k, 64'(ops_done[k] - start), 64'(NOPS));
    endtask

    initial begin
        for (int k = 0; k < NW; k++) begin
            reset[k] = 1'b1; in_valid[k] = 1'b0; in_a[k] = '0; in_b[k] = '0;
            in_cin[k] = 1'b0; in_sub[k] = 1'b0; out_ready[k] = 1'b0;
        end
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("reset_ready", 0, in_ready[0], 1'b1);
        check("reset_sum",   0, out_sum[0], 64'd0);
        reset[0] = 1'b0;
        reset[1] = 1'b0;

        dir_op(8'h3C, 8'h5A, 1'b0, 1'b0, 9'h096, 0, 1'b0);
        dir_op(8'hFF, 8'h01, 1'b0, 1'b0, 9'h100, 0, 1'b0);
        dir_op(8'hFF, 8'hFF, 1'b1, 1'b0, 9'h1FF, 5, 1'b1);

        // Reset sampled on the 4th shift edge discards the op.
        wait_idle(0);
        in_a[0] = 64'h55; in_b[0] = 64'h0F; in_cin[0] = 1'b0; in_valid[0] = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (3) @(negedge clk);
        reset[0] = 1'b1;
        @(negedge clk);
        reset[0] = 1'b0;
        check("rst_ready", 0, in_ready[0], 1'b1);
        check("rst_valid", 0, out_valid[0], 1'b0);
        check("rst_sum",   0, out_sum[0], 64'd0);
        check("rst_busy",  0, busy[0], 1'b0);
        dir_op(8'h01, 8'h01, 1'b0, 1'b0, 9'h002, 0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        dir_op(8'h10, 8'h01, 1'b0, 1'b1, 9'h10F, 2, 1'b0);
        dir_op(8'h01, 8'h02, 1'b1, 1'b1, 9'h0FF, 0, 1'b0);
`endif

        fork
            rand_drive(0);
            rand_drive(1);
        join

        repeat (20) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
